// File: rtl/bcd_rtc_timer.sv
// BCD real-time clock (HH:MM:SS) with a built-in prescaler, 12/24-hour display,
// range-checked time load, a minute-resolution alarm and one-cycle status strobes.
module bcd_rtc_timer #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_en,
  input  logic       i_mode_12h,
  input  logic       i_load,
  input  logic [3:0] i_set_hour_h,
  input  logic [3:0] i_set_hour_l,
  input  logic [3:0] i_set_minut_h,
  input  logic [3:0] i_set_minut_l,
  input  logic [3:0] i_set_second_h,
  input  logic [3:0] i_set_second_l,
  input  logic       i_alarm_wr,
  input  logic       i_alarm_en,
  output logic [3:0] o_hour_h,
  output logic [3:0] o_hour_l,
  output logic [3:0] o_minut_h,
  output logic [3:0] o_minut_l,
  output logic [3:0] o_second_h,
  output logic [3:0] o_second_l,
  output logic       o_pm,
  output logic       o_tick,
  output logic       o_day_wrap,
  output logic       o_alarm,
  output logic       o_load_err
);

  localparam int            PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    hour_h_q, hour_l_q, min_h_q, min_l_q, sec_h_q, sec_l_q;
  logic [3:0]    hour_h_d, hour_l_d, min_h_d, min_l_d, sec_h_d, sec_l_d;
  logic [3:0]    alm_hour_h_q, alm_hour_l_q, alm_min_h_q, alm_min_l_q;
  logic [3:0]    alm_hour_h_d, alm_hour_l_d, alm_min_h_d, alm_min_l_d;
  logic          tick_q, tick_d, day_wrap_q, day_wrap_d;
  logic          alarm_q, alarm_d, load_err_q, load_err_d;
  logic          tick_s, load_ok_s, alarm_ok_s;
  logic [3:0]    disp_hour_h_s, disp_hour_l_s;

  function automatic logic hm_valid(input logic [3:0] hh, input logic [3:0] hl,
                                    input logic [3:0] mh, input logic [3:0] ml);
    return (hl <= 4'd9) && (ml <= 4'd9) && (mh <= 4'd5) && (hh <= 4'd2) &&
           !((hh == 4'd2) && (hl > 4'd3));
  endfunction

  function automatic logic time_valid(input logic [3:0] hh, input logic [3:0] hl,
                                      input logic [3:0] mh, input logic [3:0] ml,
                                      input logic [3:0] sh, input logic [3:0] sl);
    return hm_valid(hh, hl, mh, ml) && (sh <= 4'd5) && (sl <= 4'd9);
  endfunction

  assign tick_s     = i_en && (presc_q == PRESC_MAX);
  assign load_ok_s  = time_valid(i_set_hour_h, i_set_hour_l, i_set_minut_h,
                                 i_set_minut_l, i_set_second_h, i_set_second_l);
  assign alarm_ok_s = hm_valid(i_set_hour_h, i_set_hour_l, i_set_minut_h, i_set_minut_l);

  // Next-state: load beats tick; a rejected load also swallows the tick and holds the prescaler.
  always_comb begin
    presc_d      = presc_q;
    hour_h_d     = hour_h_q;
    hour_l_d     = hour_l_q;
    min_h_d      = min_h_q;
    min_l_d      = min_l_q;
    sec_h_d      = sec_h_q;
    sec_l_d      = sec_l_q;
    alm_hour_h_d = alm_hour_h_q;
    alm_hour_l_d = alm_hour_l_q;
    alm_min_h_d  = alm_min_h_q;
    alm_min_l_d  = alm_min_l_q;
    tick_d       = 1'b0;
    day_wrap_d   = 1'b0;
    alarm_d      = 1'b0;
    load_err_d   = (i_load && !load_ok_s) || (i_alarm_wr && !alarm_ok_s);

    if (i_alarm_wr && alarm_ok_s) begin
      alm_hour_h_d = i_set_hour_h;
      alm_hour_l_d = i_set_hour_l;
      alm_min_h_d  = i_set_minut_h;
      alm_min_l_d  = i_set_minut_l;
    end else begin
      alm_hour_h_d = alm_hour_h_q;
    end

    if (i_load) begin
      if (load_ok_s) begin
        hour_h_d = i_set_hour_h;
        hour_l_d = i_set_hour_l;
        min_h_d  = i_set_minut_h;
        min_l_d  = i_set_minut_l;
        sec_h_d  = i_set_second_h;
        sec_l_d  = i_set_second_l;
        presc_d  = '0;
      end else begin
        presc_d  = presc_q;
      end
    end else if (tick_s) begin
      presc_d = '0;
      tick_d  = 1'b1;
      if (sec_l_q != 4'd9) begin
        sec_l_d = sec_l_q + 4'd1;
      end else begin
        sec_l_d = 4'd0;
        if (sec_h_q != 4'd5) begin
          sec_h_d = sec_h_q + 4'd1;
        end else begin
          sec_h_d = 4'd0;
          if (min_l_q != 4'd9) begin
            min_l_d = min_l_q + 4'd1;
          end else begin
            min_l_d = 4'd0;
            if (min_h_q != 4'd5) begin
              min_h_d = min_h_q + 4'd1;
            end else begin
              min_h_d = 4'd0;
              if ((hour_h_q == 4'd2) && (hour_l_q == 4'd3)) begin
                hour_h_d   = 4'd0;
                hour_l_d   = 4'd0;
                day_wrap_d = 1'b1;
              end else if (hour_l_q == 4'd9) begin
                hour_l_d = 4'd0;
                hour_h_d = hour_h_q + 4'd1;
              end else begin
                hour_l_d = hour_l_q + 4'd1;
              end
            end
          end
        end
      end
      alarm_d = i_alarm_en && (sec_h_d == 4'd0) && (sec_l_d == 4'd0) &&
                (min_h_d == alm_min_h_q) && (min_l_d == alm_min_l_q) &&
                (hour_h_d == alm_hour_h_q) && (hour_l_d == alm_hour_l_q);
    end else if (i_en) begin
      presc_d = presc_q + 1'b1;
    end else begin
      presc_d = presc_q;
    end
  end

  // 12-hour mapping: 00 -> 12, 13..19 -> 01..07, 20..21 -> 08..09, 22..23 -> 10..11.
  always_comb begin
    disp_hour_h_s = hour_h_q;
    disp_hour_l_s = hour_l_q;
    if (i_mode_12h) begin
      if ((hour_h_q == 4'd0) && (hour_l_q == 4'd0)) begin
        disp_hour_h_s = 4'd1;
        disp_hour_l_s = 4'd2;
      end else if ((hour_h_q == 4'd1) && (hour_l_q >= 4'd3)) begin
        disp_hour_h_s = 4'd0;
        disp_hour_l_s = hour_l_q - 4'd2;
      end else if ((hour_h_q == 4'd2) && (hour_l_q <= 4'd1)) begin
        disp_hour_h_s = 4'd0;
        disp_hour_l_s = hour_l_q + 4'd8;
      end else if (hour_h_q == 4'd2) begin
        disp_hour_h_s = 4'd1;
        disp_hour_l_s = hour_l_q - 4'd2;
      end else begin
        disp_hour_h_s = hour_h_q;
        disp_hour_l_s = hour_l_q;
      end
    end else begin
      disp_hour_h_s = hour_h_q;
      disp_hour_l_s = hour_l_q;
    end
  end

  // State and strobe registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      presc_q      <= '0;
      hour_h_q     <= 4'd0;
      hour_l_q     <= 4'd0;
      min_h_q      <= 4'd0;
      min_l_q      <= 4'd0;
      sec_h_q      <= 4'd0;
      sec_l_q      <= 4'd0;
      alm_hour_h_q <= 4'd0;
      alm_hour_l_q <= 4'd0;
      alm_min_h_q  <= 4'd0;
      alm_min_l_q  <= 4'd0;
      tick_q       <= 1'b0;
      day_wrap_q   <= 1'b0;
      alarm_q      <= 1'b0;
      load_err_q   <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      hour_h_q     <= hour_h_d;
      hour_l_q     <= hour_l_d;
      min_h_q      <= min_h_d;
      min_l_q      <= min_l_d;
      sec_h_q      <= sec_h_d;
      sec_l_q      <= sec_l_d;
      alm_hour_h_q <= alm_hour_h_d;
      alm_hour_l_q <= alm_hour_l_d;
      alm_min_h_q  <= alm_min_h_d;
      alm_min_l_q  <= alm_min_l_d;
      tick_q       <= tick_d;
      day_wrap_q   <= day_wrap_d;
      alarm_q      <= alarm_d;
      load_err_q   <= load_err_d;
    end
  end

  assign o_hour_h   = disp_hour_h_s;
  assign o_hour_l   = disp_hour_l_s;
  assign o_minut_h  = min_h_q;
  assign o_minut_l  = min_l_q;
  assign o_second_h = sec_h_q;
  assign o_second_l = sec_l_q;
  assign o_pm       = (hour_h_q == 4'd2) || ((hour_h_q == 4'd1) && (hour_l_q >= 4'd2));
  assign o_tick     = tick_q;
  assign o_day_wrap = day_wrap_q;
  assign o_alarm    = alarm_q;
  assign o_load_err = load_err_q;

endmodule

// File: tb/tb_bcd_rtc_timer.sv
// Directed self-checking bench for bcd_rtc_timer with TICK_DIV = 4.
module tb_bcd_rtc_timer;

  logic       clk, rst, en, mode_12h, load, alarm_wr, alarm_en;
  logic [3:0] s_hh, s_hl, s_mh, s_ml, s_sh, s_sl;
  logic [3:0] hh, hl, mh, ml, sh, sl;
  logic       pm, tick, day_wrap, alarm, load_err;
  logic [23:0] disp;
  int n_cmp, n_err, cnt;

  bcd_rtc_timer #(.TICK_DIV(4)) dut (
    .i_clk(clk), .i_reset(rst), .i_en(en), .i_mode_12h(mode_12h), .i_load(load),
    .i_set_hour_h(s_hh), .i_set_hour_l(s_hl), .i_set_minut_h(s_mh),
    .i_set_minut_l(s_ml), .i_set_second_h(s_sh), .i_set_second_l(s_sl),
    .i_alarm_wr(alarm_wr), .i_alarm_en(alarm_en),
    .o_hour_h(hh), .o_hour_l(hl), .o_minut_h(mh), .o_minut_l(ml),
    .o_second_h(sh), .o_second_l(sl), .o_pm(pm), .o_tick(tick),
    .o_day_wrap(day_wrap), .o_alarm(alarm), .o_load_err(load_err)
  );

  assign disp = {hh, hl, mh, ml, sh, sl};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_t(input logic [23:0] t);
    {s_hh, s_hl, s_mh, s_ml, s_sh, s_sl} = t;
  endtask

  task automatic do_load(input logic [23:0] t);
    set_t(t);
    load = 1'b1;
    cyc();
    load = 1'b0;
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rst = 1'b1; en = 1'b0; mode_12h = 1'b0; load = 1'b0; alarm_wr = 1'b0; alarm_en = 1'b0;
    set_t(24'h000000);
    #2;
    chk("reset_time24", disp, 24'h000000);
    chk("reset_strobes", {pm, tick, day_wrap, alarm, load_err}, 5'b00000);
    mode_12h = 1'b1; #1;
    chk("reset_time12", disp, 24'h120000);
    chk("reset_pm12", pm, 1'b0);
    mode_12h = 1'b0;

    @(posedge clk); #1;
    rst = 1'b0; en = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      cyc();
      chk($sformatf("run_tick_%0d", i), tick, (i % 4 == 0) ? 1'b1 : 1'b0);
    end
    chk("run40_time", disp, 24'h000010);

    do_load(24'h235958);
    chk("load_235958", disp, 24'h235958);
    chk("load_no_tick", tick, 1'b0);
    cnt = 0;
    for (int i = 1; i <= 8; i++) begin
      cyc();
      if (day_wrap) cnt++;
      if (i == 4) begin
        chk("t_235959", disp, 24'h235959);
        chk("t_235959_tick", {tick, day_wrap}, 2'b10);
      end
      if (i == 8) begin
        chk("t_000000", disp, 24'h000000);
        chk("wrap_with_tick", {tick, day_wrap}, 2'b11);
      end
    end
    chk("wrap_count", cnt, 1);

    en = 1'b0; mode_12h = 1'b1;
    do_load(24'h003000);
    chk("h12_00", {disp, pm}, {24'h123000, 1'b0});
    do_load(24'h120000);
    chk("h12_12", {disp, pm}, {24'h120000, 1'b1});
    do_load(24'h130500);
    chk("h12_13", {disp, pm}, {24'h010500, 1'b1});
    mode_12h = 1'b0; #1;
    chk("mode_toggle_24", {disp, pm}, {24'h130500, 1'b1});

    do_load(24'h240000);
    chk("bad_24_err", load_err, 1'b1);
    chk("bad_24_hold", disp, 24'h130500);
    cyc();
    chk("err_one_cycle", load_err, 1'b0);
    do_load(24'h126000);
    chk("bad_60_err", load_err, 1'b1);
    chk("bad_60_hold", disp, 24'h130500);
    do_load(24'h095A00);
    chk("bad_5A_err", load_err, 1'b1);
    chk("bad_5A_hold", disp, 24'h130500);

    set_t(24'h070000);
    alarm_wr = 1'b1;
    cyc();
    alarm_wr = 1'b0;
    chk("alarm_wr_ok", load_err, 1'b0);
    alarm_en = 1'b1;
    do_load(24'h065959);
    en = 1'b1;
    cnt = 0;
    for (int i = 1; i <= 8; i++) begin
      cyc();
      if (alarm) cnt++;
      if (i == 4) chk("alarm_fire", {disp, alarm, tick}, {24'h070000, 2'b11});
    end
    chk("alarm_count", cnt, 1);

    alarm_en = 1'b0;
    do_load(24'h065959);
    cnt = 0;
    for (int i = 1; i <= 8; i++) begin
      cyc();
      if (alarm) cnt++;
    end
    chk("alarm_dis_count", cnt, 0);
    chk("alarm_dis_time", disp, 24'h070001);

    alarm_en = 1'b1;
    do_load(24'h070000);
    cnt = 0;
    if (alarm) cnt++;
    for (int i = 1; i <= 3; i++) begin
      cyc();
      if (alarm || tick) cnt++;
    end
    chk("load_no_alarm", cnt, 0);

    do_load(24'h102030);
    chk("tickload_time", disp, 24'h102030);
    chk("tickload_no_tick", {tick, alarm}, 2'b00);
    cnt = 0;
    for (int i = 1; i <= 3; i++) begin
      cyc();
      if (tick) cnt++;
    end
    chk("restart_quiet", cnt, 0);
    cyc();
    chk("restart_tick", {disp, tick}, {24'h102031, 1'b1});

    cnt = 0;
    cyc(); if (tick) cnt++;
    cyc(); if (tick) cnt++;
    en = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      cyc();
      if (tick) cnt++;
    end
    en = 1'b1;
    cyc(); if (tick) cnt++;
    chk("stretch_quiet", cnt, 0);
    cyc();
    chk("stretch_tick", {disp, tick}, {24'h102032, 1'b1});

    rst = 1'b1; #1;
    chk("async_rst_time", disp, 24'h000000);
    chk("async_rst_strobes", {pm, tick, day_wrap, alarm, load_err}, 5'b00000);
    mode_12h = 1'b1; #1;
    chk("async_rst_12h", {disp, pm}, {24'h120000, 1'b0});
    cyc();
    chk("rst_held_tick", tick, 1'b0);
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
